elevator_controller: RTL and testbench
======================================

// Module: elevator_controller
// PURPOSE
//  Single-car dispatcher: consumes latched hall/car calls (upcall, downcall, floor_btn)
//  from the status input buffer and drives the car position and motion/door status.
//  floor/status are fed back to the buffer, which clears calls at `floor` while status==7.
//  Collective (SCAN) scheduling; timed travel and door dwell from cycle counters.
// PARAMETERS
//  FLOORS       8   number of floors (floor index width fixed at 3 bits, FLOORS<=8)
//  MOVE_CYCLES  4   clk cycles to travel one floor (>=1)
//  DOOR_CYCLES  6   clk cycles status stays DOOR_OPEN (>=2, so the buffer clear lands)
//  HOME_CYCLES  32  idle cycles before homing (used only with ELEV_HOME_RETURN_EN)
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  rst        in   1  reset, synchronous, active-low
//  upcall     in   8  latched hall up-requests, bit i = floor i
//  downcall   in   8  latched hall down-requests
//  floor_btn  in   8  latched car-panel requests
//  floor      out  3  current car floor
//  status     out  4  0 IDLE, 1 MOVE_UP, 2 MOVE_DOWN, 7 DOOR_OPEN (4'd7 is the clear code)
//  dir        out  2  scan direction: 00 none, 01 up, 10 down
// BEHAVIOUR
//  - Reset (rst==0 at edge): floor=0, status=0, dir=00, travel/door/idle counters=0.
//    Reset mid-travel or mid-door aborts immediately; car snaps to floor 0 model state.
//  - req = upcall|downcall|floor_btn (bits >= FLOORS ignored). above/below = any req
//    bit strictly above/below floor; here = req[floor].
//  - IDLE: here -> DOOR_OPEN next edge (dir unchanged); else above -> MOVE_UP, dir=01;
//    else below -> MOVE_DOWN, dir=10; else stay. here has priority; above beats below.
//  - MOVE_UP/DOWN: counter increments each cycle; at count==MOVE_CYCLES-1 floor<=floor±1,
//    counter<=0, and the stop decision for the NEW floor n is taken at that same edge:
//    up: stop if floor_btn[n]|upcall[n]|(downcall[n] & no req above n);
//    down: mirror (downcall primary, upcall only if no req below n).
//    stop -> status 7 together with new floor. No stop and requests remain ahead -> keep moving.
//    No req at all (calls vanished) -> IDLE at n, no door.
//  - Limits: never increments past FLOORS-1 nor decrements below 0; reaching an end
//    floor always stops (door if req[n], else IDLE).
//  - DOOR_OPEN: status==7 for exactly DOOR_CYCLES cycles; new calls at floor during
//    dwell are absorbed by the buffer clear (no reopen). On exit: requests ahead in dir
//    -> keep dir, move; else requests behind -> reverse; else IDLE, dir=00.
//  - Latency: request visible at IDLE -> status change on next edge. Floor k away:
//    floor==target and status==7 exactly k*MOVE_CYCLES cycles after leaving IDLE.
//  - Inputs sampled synchronously; no combinational path input->output.
// CONFIGURATION
//  ELEV_HOME_RETURN_EN defined: in IDLE with no req and floor!=0, idle counter counts;
//    at HOME_CYCLES it starts MOVE_DOWN to floor 0 (dir=10), arriving -> IDLE (no door)
//    unless a request exists; any req resets the counter and normal scheduling takes over.
//  Undefined: car parks where it stopped; idle counter absent.
// TESTING
//  1 rst=0 two edges -> floor=0,status=0,dir=00; then floor_btn=8'h08 -> status=1 next
//    edge, floor 1/2/3 at +4/+8/+12, status=7 at +12 for 6 cycles, then status=0,dir=00.
//  2 At floor 0 IDLE, upcall=8'h01 -> status=7 next edge, 6 cycles, buffer clears, IDLE.
//  3 Moving up from 0, upcall=8'h04 and downcall=8'h10 -> stops at 2 (status 7), then
//    continues up, stops at 4; downcall[2] alone while going up to 5 -> passes floor 2.
//  4 At floor 7 moving up, no req above -> never floor 8/0 wrap; at floor 0 going down,
//    floor stays 0; all calls cleared mid-travel -> IDLE at next floor, no door.
//  5 rst=0 asserted during DOOR_OPEN at floor 5 -> next edge floor=0,status=0,dir=00.
//  6 ELEV_HOME_RETURN_EN, idle at floor 3, no calls 32 cycles -> status=2, floor 0 after
//    12 more cycles, status=0; undefined build -> floor stays 3.

Source files
------------

// File: rtl/elevator_controller.sv
// Single-car SCAN elevator dispatcher with timed travel and door dwell.
// Optional return-to-lobby after a long idle period: define ELEV_HOME_RETURN_EN.
module elevator_controller #(
    parameter int unsigned FLOORS      = 8,
    parameter int unsigned MOVE_CYCLES = 4,
    parameter int unsigned DOOR_CYCLES = 6
`ifdef ELEV_HOME_RETURN_EN
    ,
    parameter int unsigned HOME_CYCLES = 32
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] upcall,
    input  logic [7:0] downcall,
    input  logic [7:0] floor_btn,
    output logic [2:0] floor,
    output logic [3:0] status,
    output logic [1:0] dir
);

    localparam int unsigned MoveW     = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
    localparam int unsigned DoorW     = $clog2(DOOR_CYCLES);
    localparam logic [7:0]  FloorMask = 8'((1 << FLOORS) - 1);
    localparam logic [2:0]  TopFloor  = 3'(FLOORS - 1);
    localparam logic [MoveW-1:0] MoveLast = MoveW'(MOVE_CYCLES - 1);
    localparam logic [DoorW-1:0] DoorLast = DoorW'(DOOR_CYCLES - 1);

    localparam logic [1:0] DirNone = 2'b00;
    localparam logic [1:0] DirUp   = 2'b01;
    localparam logic [1:0] DirDown = 2'b10;

    // Encodings double as the status output; 7 is the buffer's clear code.
    typedef enum logic [3:0] {
        StIdle = 4'd0,
        StUp   = 4'd1,
        StDown = 4'd2,
        StDoor = 4'd7
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       floor_q, floor_d;
    logic [1:0]       dir_q, dir_d;
    logic [MoveW-1:0] move_cnt_q, move_cnt_d;
    logic [DoorW-1:0] door_cnt_q, door_cnt_d;

    logic [7:0] up_m, dn_m, btn_m, req;
    logic       any_req, here, above, below;
    logic [2:0] floor_up, floor_dn;
    logic       stop_up, stop_dn, ahead_up, ahead_dn;
    logic       home_go, home_active;

    function automatic logic any_above(input logic [7:0] r, input logic [2:0] f);
        logic [7:0] m;
        m = 8'hFE << f;
        return |(r & m);
    endfunction

    function automatic logic any_below(input logic [7:0] r, input logic [2:0] f);
        logic [7:0] m;
        m = ~(8'hFF << f);
        return |(r & m);
    endfunction

    assign up_m    = upcall & FloorMask;
    assign dn_m    = downcall & FloorMask;
    assign btn_m   = floor_btn & FloorMask;
    assign req     = up_m | dn_m | btn_m;
    assign any_req = |req;
    assign here    = req[floor_q];
    assign above   = any_above(req, floor_q);
    assign below   = any_below(req, floor_q);

    // Saturate at the shaft ends so the floor index can never wrap.
    assign floor_up = (floor_q == TopFloor) ? floor_q : floor_q + 3'd1;
    assign floor_dn = (floor_q == 3'd0) ? floor_q : floor_q - 3'd1;

    // Opposite-direction hall calls are only served when nothing lies further ahead.
    assign ahead_up = any_above(req, floor_up);
    assign ahead_dn = any_below(req, floor_dn);
    assign stop_up  = btn_m[floor_up] | up_m[floor_up] | (dn_m[floor_up] & ~ahead_up);
    assign stop_dn  = btn_m[floor_dn] | dn_m[floor_dn] | (up_m[floor_dn] & ~ahead_dn);

    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        dir_d      = dir_q;
        move_cnt_d = move_cnt_q;
        door_cnt_d = door_cnt_q;
        unique case (state_q)
            StIdle: begin
                move_cnt_d = '0;
                door_cnt_d = '0;
                if (here) begin
                    state_d = StDoor;
                end else if (above) begin
                    state_d = StUp;
                    dir_d   = DirUp;
                end else if (below) begin
                    state_d = StDown;
                    dir_d   = DirDown;
                end else if (home_go) begin
                    state_d = StDown;
                    dir_d   = DirDown;
                end
            end
            StUp: begin
                if (move_cnt_q != MoveLast) begin
                    move_cnt_d = move_cnt_q + 1'b1;
                end else begin
                    move_cnt_d = '0;
                    floor_d    = floor_up;
                    if (stop_up) begin
                        state_d = StDoor;
                    end else if ((floor_up == TopFloor) || !ahead_up) begin
                        state_d = StIdle;
                        dir_d   = DirNone;
                    end
                end
            end
            StDown: begin
                if (move_cnt_q != MoveLast) begin
                    move_cnt_d = move_cnt_q + 1'b1;
                end else begin
                    move_cnt_d = '0;
                    floor_d    = floor_dn;
                    if (stop_dn) begin
                        state_d = StDoor;
                    end else if (floor_dn == 3'd0) begin
                        state_d = StIdle;
                        dir_d   = DirNone;
                    end else if (!ahead_dn && !(home_active && !any_req)) begin
                        state_d = StIdle;
                        dir_d   = DirNone;
                    end
                end
            end
            StDoor: begin
                move_cnt_d = '0;
                if (door_cnt_q != DoorLast) begin
                    door_cnt_d = door_cnt_q + 1'b1;
                end else begin
                    door_cnt_d = '0;
                    if (dir_q == DirDown && below) begin
                        state_d = StDown;
                    end else if (above) begin
                        state_d = StUp;
                        dir_d   = DirUp;
                    end else if (below) begin
                        state_d = StDown;
                        dir_d   = DirDown;
                    end else begin
                        state_d = StIdle;
                        dir_d   = DirNone;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                dir_d   = DirNone;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            floor_q    <= 3'd0;
            dir_q      <= DirNone;
            move_cnt_q <= '0;
            door_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            floor_q    <= floor_d;
            dir_q      <= dir_d;
            move_cnt_q <= move_cnt_d;
            door_cnt_q <= door_cnt_d;
        end
    end

`ifdef ELEV_HOME_RETURN_EN
    localparam int unsigned IdleW = $clog2(HOME_CYCLES + 1);
    localparam logic [IdleW-1:0] IdleLast = IdleW'(HOME_CYCLES - 1);

    logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
    logic             home_q, home_d;
    logic             idle_wait;

    assign idle_wait   = (state_q == StIdle) && !any_req && (floor_q != 3'd0);
    assign home_go     = idle_wait && (idle_cnt_q == IdleLast);
    assign home_active = home_q;

    // home_q lets the homing run pass floors without calls instead of parking.
    always_comb begin
        idle_cnt_d = (idle_wait && !home_go) ? idle_cnt_q + 1'b1 : '0;
        if (any_req || state_d != StDown) begin
            home_d = 1'b0;
        end else if (home_go) begin
            home_d = 1'b1;
        end else begin
            home_d = home_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idle_cnt_q <= '0;
            home_q     <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            home_q     <= home_d;
        end
    end
`else
    assign home_go     = 1'b0;
    assign home_active = 1'b0;
`endif

    assign floor  = floor_q;
    assign status = state_q;
    assign dir    = dir_q;

endmodule

// File: tb/tb_elevator_controller.sv
// Directed bench for elevator_controller; also models the call buffer,
// which drops calls at the car's floor while status reads 7.
module tb_elevator_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] upcall;
    logic [7:0] downcall;
    logic [7:0] floor_btn;
    logic [2:0] floor;
    logic [3:0] status;
    logic [1:0] dir;

    int vectors     = 0;
    int miscompares = 0;

    elevator_controller dut (
        .clk       (clk),
        .rst       (rst),
        .upcall    (upcall),
        .downcall  (downcall),
        .floor_btn (floor_btn),
        .floor     (floor),
        .status    (status),
        .dir       (dir)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (status == 4'd7) begin
                upcall[floor]    = 1'b0;
                downcall[floor]  = 1'b0;
                floor_btn[floor] = 1'b0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_car(input string tag, input logic [2:0] f, input logic [3:0] s,
                           input logic [1:0] d);
        chk({tag, ".floor"}, 8'(floor), 8'(f));
        chk({tag, ".status"}, 8'(status), 8'(s));
        chk({tag, ".dir"}, 8'(dir), 8'(d));
    endtask

    initial begin
        rst       = 1'b0;
        upcall    = 8'h00;
        downcall  = 8'h00;
        floor_btn = 8'h00;

        // Reset, then a car call three floors up.
        tick(2);  chk_car("reset", 3'd0, 4'd0, 2'd0);
        rst = 1'b1;
        floor_btn = 8'h08;
        tick(1);  chk_car("t1_depart", 3'd0, 4'd1, 2'd1);
        tick(3);  chk_car("t1_pre_f1", 3'd0, 4'd1, 2'd1);
        tick(1);  chk_car("t1_f1", 3'd1, 4'd1, 2'd1);
        tick(4);  chk_car("t1_f2", 3'd2, 4'd1, 2'd1);
        tick(4);  chk_car("t1_f3_door", 3'd3, 4'd7, 2'd1);
        tick(5);  chk_car("t1_door_last", 3'd3, 4'd7, 2'd1);
        tick(1);  chk_car("t1_idle", 3'd3, 4'd0, 2'd0);

        // Call at the current floor opens the door without moving.
        rst = 1'b0; tick(1); rst = 1'b1;
        chk_car("t2_reset", 3'd0, 4'd0, 2'd0);
        upcall = 8'h01;
        tick(1);  chk_car("t2_door", 3'd0, 4'd7, 2'd0);
        tick(5);  chk_car("t2_door_last", 3'd0, 4'd7, 2'd0);
        tick(1);  chk_car("t2_idle", 3'd0, 4'd0, 2'd0);

        // Collective up-scan: upcall stop, then topmost downcall stop.
        upcall = 8'h04; downcall = 8'h10;
        tick(1);  chk_car("t3_depart", 3'd0, 4'd1, 2'd1);
        tick(8);  chk_car("t3_stop2", 3'd2, 4'd7, 2'd1);
        tick(6);  chk_car("t3_resume", 3'd2, 4'd1, 2'd1);
        tick(8);  chk_car("t3_stop4", 3'd4, 4'd7, 2'd1);
        tick(6);  chk_car("t3_idle4", 3'd4, 4'd0, 2'd0);

        // Downcall passed while going up, served after reversing.
        rst = 1'b0; tick(1); rst = 1'b1;
        downcall = 8'h04; floor_btn = 8'h20;
        tick(1);  chk_car("t3b_depart", 3'd0, 4'd1, 2'd1);
        tick(8);  chk_car("t3b_pass2", 3'd2, 4'd1, 2'd1);
        tick(12); chk_car("t3b_stop5", 3'd5, 4'd7, 2'd1);
        tick(6);  chk_car("t3b_reverse", 3'd5, 4'd2, 2'd2);
        tick(12); chk_car("t3b_stop2", 3'd2, 4'd7, 2'd2);
        tick(6);  chk_car("t3b_idle2", 3'd2, 4'd0, 2'd0);

        // Shaft ends and calls vanishing mid-travel.
        floor_btn = 8'h80;
        tick(1);  chk_car("t4_up", 3'd2, 4'd1, 2'd1);
        tick(20); chk_car("t4_top", 3'd7, 4'd7, 2'd1);
        tick(6);  chk_car("t4_top_idle", 3'd7, 4'd0, 2'd0);
        tick(3);  chk_car("t4_no_wrap", 3'd7, 4'd0, 2'd0);
        floor_btn = 8'h01;
        tick(1);  chk_car("t4_down", 3'd7, 4'd2, 2'd2);
        tick(28); chk_car("t4_bottom", 3'd0, 4'd7, 2'd2);
        tick(6);  chk_car("t4_bottom_idle", 3'd0, 4'd0, 2'd0);
        tick(3);  chk_car("t4_stay0", 3'd0, 4'd0, 2'd0);
        floor_btn = 8'h10;
        tick(1);  chk_car("t4_go", 3'd0, 4'd1, 2'd1);
        tick(2);
        floor_btn = 8'h00;
        tick(1);  chk_car("t4_still_moving", 3'd0, 4'd1, 2'd1);
        tick(1);  chk_car("t4_idle_no_door", 3'd1, 4'd0, 2'd0);

        // Reset during door dwell at floor 5.
        floor_btn = 8'h20;
        tick(1);  chk_car("t5_depart", 3'd1, 4'd1, 2'd1);
        tick(16); chk_car("t5_door", 3'd5, 4'd7, 2'd1);
        tick(2);  chk_car("t5_door_mid", 3'd5, 4'd7, 2'd1);
        rst = 1'b0;
        tick(1);  chk_car("t5_reset", 3'd0, 4'd0, 2'd0);
        rst = 1'b1;

        // Long idle away from the lobby.
        floor_btn = 8'h08;
        tick(13); chk_car("t6_door3", 3'd3, 4'd7, 2'd1);
        tick(6);  chk_car("t6_idle3", 3'd3, 4'd0, 2'd0);
        tick(31); chk_car("t6_wait", 3'd3, 4'd0, 2'd0);
        tick(1);
`ifdef ELEV_HOME_RETURN_EN
        chk_car("t6_home_start", 3'd3, 4'd2, 2'd2);
        tick(11); chk_car("t6_home_f1", 3'd1, 4'd2, 2'd2);
        tick(1);  chk_car("t6_home", 3'd0, 4'd0, 2'd0);
`else
        chk_car("t6_parked", 3'd3, 4'd0, 2'd0);
        tick(12); chk_car("t6_parked_late", 3'd3, 4'd0, 2'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
